seven_segment_scan_reader: RTL and testbench
============================================

Name: seven_segment_scan_reader

Overview:
- Reader end of the multiplexed seven-segment display interface.
- Samples the segment bus and one-hot digit strobes that a scanning display driver produces.
- Qualifies each digit's pattern for stability, then decodes it back to BCD.
- Presents a complete, atomically updated multi-digit BCD word once per scan frame.
- Used as a display loop-back checker and as the bench-side monitor for segment drivers.

Parameters:
- NUM_DIGITS, 4: number of multiplexed digits (2 to 8).
- STABLE_CYCLES, 3: consecutive identical samples needed before capture (1 to 15).

Ports:
- clk  input  1  single system clock; all logic is rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- seg_in  input  7  segment pattern, {a,b,c,d,e,f,g}; seg_in[6]=a; active-high by default.
- dig_sel  input  NUM_DIGITS  one-hot digit strobe, active-high; bit i means digit i.
- err_clr  input  1  synchronous clear of digit_err.
- bcd_out  output  4*NUM_DIGITS  decoded digits; digit i is bcd_out[4i+3:4i].
- frame_valid  output  1  one-cycle pulse when bcd_out updates.
- digit_err  output  NUM_DIGITS  sticky per-digit invalid-pattern flags.

Behaviour:
- Reset (async assert, sync release):
  - bcd_out=0, frame_valid=0, digit_err=0.
  - Shadow digits=0, capture mask=0, stability counter=0, state=IDLE.
- Input sampling: seg_in and dig_sel are registered once per cycle (sample stage). All qualification uses the registered values.
- State machine:
  - IDLE: the sample is zero or not one-hot. Counter held at 0. Go to SETTLE on the first cycle with a valid one-hot sample.
  - SETTLE: if the sample equals the previous sample, the counter increments. Any change restarts the count, with the new sample treated as the first. A non-one-hot sample returns to IDLE.
  - SETTLE, capture point: on the edge where STABLE_CYCLES consecutive identical samples exist, capture and go to CAPTURED.
  - CAPTURED: hold with no further capture until the sample changes. A new one-hot value goes to SETTLE with count 1. An invalid value goes to IDLE.
- Capture:
  - Decode the pattern into shadow digit i and set mask bit i.
  - A recapture of the same digit before the frame completes overwrites its shadow entry.
- Decode table (seg abcdefg -> BCD):
  - 1111110 -> 0, 0110000 -> 1, 1101101 -> 2, 1111001 -> 3, 1111011 -> 9
  - 0110011 -> 4, 1011011 -> 5, 1011111 -> 6, 1110000 -> 7, 1111111 -> 8
  - Any other pattern, including blank: shadow nibble = 4'hF and digit_err[i] is set.
- Frame completion:
  - On the edge after the capture that makes the mask all ones, bcd_out is loaded from the full shadow in one update.
  - frame_valid is high for exactly that one cycle, and the mask clears.
  - Latency from a stable strobe at the first sampling edge: capture at edge STABLE_CYCLES+1; bcd_out/frame_valid at edge STABLE_CYCLES+2.
- bcd_out holds its value between frames and never shows a partial frame.
- digit_err: err_clr clears all bits. If err_clr and a new error occur in the same cycle, the new error bit is set.
- Reset mid-frame discards the shadow and mask. The next frame requires all digits again.

Optional Feature:
- Macro: SEG_ACTIVE_LOW_EN.
- Defined: seg_in is inverted at the sample stage, for common-anode displays. The decode table and all other behaviour are unchanged.
- Undefined: seg_in is used active-high as received.

Decomposition:
- Package seven_seg_pkg holds:
  - SEG_0..SEG_9 pattern constants, SEG_BLANK.
  - BCD_ERR = 4'hF.
  - The state enum typedef (IDLE, SETTLE, CAPTURED).
- Sub-module seg_pattern_to_bcd: combinational 7-bit to {valid, 4-bit} lookup, instantiated once on the sampled pattern.

Test Plan:
- Scan digits 0..3 with patterns for 1, 2, 3, 4, each held 5 cycles, STABLE_CYCLES=3 -> one frame_valid pulse; bcd_out=16'h4321; digit_err=0.
- Hold digit 0 stable for only 2 cycles, then move to digit 1 -> no capture of digit 0; frame_valid stays 0 until digit 0 is later held for 3 or more cycles.
- Drive 0000001 on digit 2 while the other digits are valid -> frame completes with nibble 2 = 4'hF and digit_err=4'b0100; pulse err_clr -> digit_err=0.
- dig_sel=4'b0011 for 10 cycles, then zero -> no captures; state returns to IDLE; bcd_out unchanged.
- Assert rst_n=0 after 3 of 4 digits are captured, release, then scan a full frame of 9, 8, 7, 6 -> a single frame_valid; bcd_out=16'h6789, with no earlier partial output.
- With SEG_ACTIVE_LOW_EN defined, drive ~1111110 on all digits -> bcd_out=16'h0000 and no errors.

Source files
------------

// File: rtl/seven_seg_pkg.sv
// Shared constants for the seven-segment scan reader: segment patterns ({a,b,c,d,e,f,g}),
// the BCD error code and the qualification state type.
package seven_seg_pkg;

  localparam logic [6:0] SEG_0     = 7'b1111110;
  localparam logic [6:0] SEG_1     = 7'b0110000;
  localparam logic [6:0] SEG_2     = 7'b1101101;
  localparam logic [6:0] SEG_3     = 7'b1111001;
  localparam logic [6:0] SEG_4     = 7'b0110011;
  localparam logic [6:0] SEG_5     = 7'b1011011;
  localparam logic [6:0] SEG_6     = 7'b1011111;
  localparam logic [6:0] SEG_7     = 7'b1110000;
  localparam logic [6:0] SEG_8     = 7'b1111111;
  localparam logic [6:0] SEG_9     = 7'b1111011;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  localparam logic [3:0] BCD_ERR = 4'hF;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SETTLE   = 2'd1,
    CAPTURED = 2'd2
  } scan_state_e;

endpackage

// File: rtl/seg_pattern_to_bcd.sv
// Combinational segment-pattern to BCD lookup; unknown patterns (including blank)
// return BCD_ERR with valid low.
module seg_pattern_to_bcd
  import seven_seg_pkg::*;
(
  input  logic [6:0] seg,
  output logic       valid,
  output logic [3:0] bcd
);

  always_comb begin
    valid = 1'b1;
    bcd   = BCD_ERR;
    case (seg)
      SEG_0:   bcd = 4'd0;
      SEG_1:   bcd = 4'd1;
      SEG_2:   bcd = 4'd2;
      SEG_3:   bcd = 4'd3;
      SEG_4:   bcd = 4'd4;
      SEG_5:   bcd = 4'd5;
      SEG_6:   bcd = 4'd6;
      SEG_7:   bcd = 4'd7;
      SEG_8:   bcd = 4'd8;
      SEG_9:   bcd = 4'd9;
      default: valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/seven_segment_scan_reader.sv
// Reader for a multiplexed seven-segment bus: qualifies each strobed digit, decodes it to
// BCD and publishes a whole frame atomically. Define SEG_ACTIVE_LOW_EN for common-anode buses.
module seven_segment_scan_reader
  import seven_seg_pkg::*;
#(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [6:0]              seg_in,
  input  logic [NUM_DIGITS-1:0]   dig_sel,
  input  logic                    err_clr,
  output logic [4*NUM_DIGITS-1:0] bcd_out,
  output logic                    frame_valid,
  output logic [NUM_DIGITS-1:0]   digit_err
);

  logic [6:0]              seg_d, seg_q, prev_seg_q;
  logic [NUM_DIGITS-1:0]   dig_q, prev_dig_q;
  scan_state_e             state_d, state_q;
  logic [3:0]              cnt_d, cnt_q, run_len;
  logic                    sample_valid, same_sample, capture;
  logic                    pat_valid;
  logic [3:0]              pat_bcd;
  logic [NUM_DIGITS-1:0]   mask_d, mask_q, err_d, err_q;
  logic                    pending_d, pending_q, fv_d, fv_q;
  logic [4*NUM_DIGITS-1:0] shadow_flat, bcd_d, bcd_q;

  always_comb begin
`ifdef SEG_ACTIVE_LOW_EN
    seg_d = ~seg_in;
`else
    seg_d = seg_in;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_q      <= '0;
      dig_q      <= '0;
      prev_seg_q <= '0;
      prev_dig_q <= '0;
    end else begin
      seg_q      <= seg_d;
      dig_q      <= dig_sel;
      prev_seg_q <= seg_q;
      prev_dig_q <= dig_q;
    end
  end

  assign sample_valid = $onehot(dig_q);
  assign same_sample  = (seg_q == prev_seg_q) && (dig_q == prev_dig_q);
  // Length of the current run of identical samples, counting this one.
  assign run_len      = (state_q == SETTLE && same_sample) ? cnt_q + 4'd1 : 4'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (sample_valid) state_d = capture ? CAPTURED : SETTLE;
      SETTLE:   if (!sample_valid) state_d = IDLE;
                else if (capture) state_d = CAPTURED;
      CAPTURED: if (!sample_valid) state_d = IDLE;
                else if (!same_sample) state_d = capture ? CAPTURED : SETTLE;
      default:  state_d = IDLE;
    endcase
  end

  always_comb begin
    capture = sample_valid && (run_len == 4'(STABLE_CYCLES)) &&
              !(state_q == CAPTURED && same_sample);
    cnt_d   = (state_d == SETTLE) ? run_len : 4'd0;
  end

  seg_pattern_to_bcd u_decode (
    .seg   (seg_q),
    .valid (pat_valid),
    .bcd   (pat_bcd)
  );

  generate
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_shadow
      logic [3:0] shadow_d, shadow_q;

      assign shadow_d = (capture && dig_q[gi]) ? pat_bcd : shadow_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) shadow_q <= '0;
        else        shadow_q <= shadow_d;
      end

      assign shadow_flat[4*gi +: 4] = shadow_q;
    end
  endgenerate

  // A pending frame is published one edge after its last capture, then the mask restarts.
  always_comb begin
    mask_d    = (pending_q ? '0 : mask_q) | (capture ? dig_q : '0);
    pending_d = capture && (&mask_d);
    fv_d      = pending_q;
    bcd_d     = pending_q ? shadow_flat : bcd_q;
    err_d     = (err_clr ? '0 : err_q) | ((capture && !pat_valid) ? dig_q : '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mask_q    <= '0;
      pending_q <= 1'b0;
      fv_q      <= 1'b0;
      bcd_q     <= '0;
      err_q     <= '0;
    end else begin
      mask_q    <= mask_d;
      pending_q <= pending_d;
      fv_q      <= fv_d;
      bcd_q     <= bcd_d;
      err_q     <= err_d;
    end
  end

  assign bcd_out     = bcd_q;
  assign frame_valid = fv_q;
  assign digit_err   = err_q;

endmodule

// File: tb/tb_seven_segment_scan_reader.sv
// Self-checking bench for seven_segment_scan_reader: a run-length reference model checked
// every cycle, plus literal expectations from directed scan sequences.
module tb_seven_segment_scan_reader;

  localparam int N = 4;
  localparam int S = 3;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [6:0]     pat_drv = 7'b0;
  logic [6:0]     seg_in;
  logic [N-1:0]   dig_sel = '0;
  logic           err_clr = 1'b0;
  logic [4*N-1:0] bcd_out;
  logic           frame_valid;
  logic [N-1:0]   digit_err;

`ifdef SEG_ACTIVE_LOW_EN
  assign seg_in = ~pat_drv;
`else
  assign seg_in = pat_drv;
`endif

  seven_segment_scan_reader #(.NUM_DIGITS(N), .STABLE_CYCLES(S)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .seg_in      (seg_in),
    .dig_sel     (dig_sel),
    .err_clr     (err_clr),
    .bcd_out     (bcd_out),
    .frame_valid (frame_valid),
    .digit_err   (digit_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int frames = 0;

  logic [6:0] pat_tab [10] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
                               7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011};

  function automatic logic [4:0] ref_decode(input logic [6:0] p);
    for (int v = 0; v < 10; v++)
      if (pat_tab[v] == p) return {1'b1, 4'(v)};
    return {1'b0, 4'hF};
  endfunction

  // Reference model: a digit is captured when the registered sample has been the same
  // valid one-hot value for exactly S consecutive edges; frames publish one edge later.
  logic [6:0]     m_seg, m_seg_prev;
  logic [N-1:0]   m_dig, m_dig_prev, m_mask, m_err, m_new_err;
  logic [3:0]     m_shadow [N];
  logic [4*N-1:0] m_bcd;
  logic           m_pend, m_fv;
  logic [4:0]     m_dec;
  int             m_run;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_seg = '0; m_seg_prev = '0; m_dig = '0; m_dig_prev = '0;
      m_mask = '0; m_err = '0; m_bcd = '0; m_pend = 1'b0; m_fv = 1'b0; m_run = 0;
      for (int i = 0; i < N; i++) m_shadow[i] = 4'h0;
    end else begin
      m_fv = m_pend;
      if (m_pend) begin
        for (int i = 0; i < N; i++) m_bcd[4*i +: 4] = m_shadow[i];
        m_mask = '0;
        m_pend = 1'b0;
      end
      m_new_err = '0;
      if ($onehot(m_dig))
        m_run = (m_run > 0 && m_seg == m_seg_prev && m_dig == m_dig_prev) ? m_run + 1 : 1;
      else
        m_run = 0;
      if (m_run == S) begin
        m_dec = ref_decode(m_seg);
        for (int i = 0; i < N; i++)
          if (m_dig[i]) begin
            m_shadow[i] = m_dec[3:0];
            if (!m_dec[4]) m_new_err[i] = 1'b1;
          end
        m_mask = m_mask | m_dig;
        if (&m_mask) m_pend = 1'b1;
      end
      m_err = (err_clr ? '0 : m_err) | m_new_err;
      m_seg_prev = m_seg; m_dig_prev = m_dig;
      m_seg = pat_drv;    m_dig = dig_sel;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (frame_valid) frames++;
      checks++;
      if (bcd_out !== m_bcd) begin
        errors++;
        $display("FAIL model_bcd t=%0t got=%h want=%h", $time, bcd_out, m_bcd);
      end
      checks++;
      if (frame_valid !== m_fv) begin
        errors++;
        $display("FAIL model_fv t=%0t got=%b want=%b", $time, frame_valid, m_fv);
      end
      checks++;
      if (digit_err !== m_err) begin
        errors++;
        $display("FAIL model_err t=%0t got=%b want=%b", $time, digit_err, m_err);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end else
      $display("ok   %s = %h", name, act);
  endtask

  task automatic hold(input logic [N-1:0] sel, input logic [6:0] p, input int n);
    repeat (n) begin
      pat_drv = p;
      dig_sel = sel;
      @(negedge clk);
    end
  endtask

  int f0;

  initial begin
    @(negedge clk);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    chk("reset_bcd", 32'(bcd_out), 32'h0);
    chk("reset_fv", 32'(frame_valid), 32'h0);
    chk("reset_err", 32'(digit_err), 32'h0);

    // Full scan of 1,2,3,4
    f0 = frames;
    hold(4'b0001, 7'b0110000, 5);
    hold(4'b0010, 7'b1101101, 5);
    hold(4'b0100, 7'b1111001, 5);
    hold(4'b1000, 7'b0110011, 5);
    hold(4'b0000, 7'b0000000, 3);
    chk("t1_frames", 32'(frames - f0), 32'd1);
    chk("t1_bcd", 32'(bcd_out), 32'h4321);
    chk("t1_err", 32'(digit_err), 32'h0);

    // Digit 0 too short, then long enough
    f0 = frames;
    hold(4'b0001, 7'b1011011, 2);
    hold(4'b0010, 7'b1011111, 5);
    hold(4'b0100, 7'b1110000, 5);
    hold(4'b1000, 7'b1111111, 5);
    hold(4'b0000, 7'b0000000, 3);
    chk("t2_no_frame", 32'(frames - f0), 32'd0);
    chk("t2_bcd_held", 32'(bcd_out), 32'h4321);
    hold(4'b0001, 7'b1011011, 4);
    hold(4'b0000, 7'b0000000, 3);
    chk("t2_frames", 32'(frames - f0), 32'd1);
    chk("t2_bcd", 32'(bcd_out), 32'h8765);

    // Invalid pattern on digit 2
    f0 = frames;
    hold(4'b0001, 7'b0110000, 5);
    hold(4'b0010, 7'b1101101, 5);
    hold(4'b0100, 7'b0000001, 5);
    hold(4'b1000, 7'b0110011, 5);
    hold(4'b0000, 7'b0000000, 3);
    chk("t3_frames", 32'(frames - f0), 32'd1);
    chk("t3_bcd", 32'(bcd_out), 32'h4F21);
    chk("t3_err", 32'(digit_err), 32'h4);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    chk("t3_err_clr", 32'(digit_err), 32'h0);

    // Two strobes at once never capture
    f0 = frames;
    hold(4'b0011, 7'b1111111, 10);
    hold(4'b0000, 7'b0000000, 3);
    chk("t4_no_frame", 32'(frames - f0), 32'd0);
    chk("t4_bcd", 32'(bcd_out), 32'h4F21);

    // Reset mid-frame, then a fresh full frame
    hold(4'b0001, 7'b0110000, 5);
    hold(4'b0010, 7'b0110000, 5);
    hold(4'b0100, 7'b0110000, 5);
    rst_n = 1'b0;
    @(negedge clk);
    chk("t5_reset_bcd", 32'(bcd_out), 32'h0);
    rst_n = 1'b1;
    f0 = frames;
    hold(4'b0001, 7'b1111011, 5);
    hold(4'b0010, 7'b1111111, 5);
    hold(4'b0100, 7'b1110000, 5);
    hold(4'b1000, 7'b1011111, 5);
    hold(4'b0000, 7'b0000000, 3);
    chk("t5_frames", 32'(frames - f0), 32'd1);
    chk("t5_bcd", 32'(bcd_out), 32'h6789);

    // All zeros (inverted on the wire when built for active-low segments)
    f0 = frames;
    for (int d = 0; d < N; d++) hold(4'(1 << d), 7'b1111110, 5);
    hold(4'b0000, 7'b0000000, 3);
    chk("t6_frames", 32'(frames - f0), 32'd1);
    chk("t6_bcd", 32'(bcd_out), 32'h0000);
    chk("t6_err", 32'(digit_err), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
